// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source (master) and product_accumulator (slave):
// burst start/length, product stream in, accumulated result out.
interface product_accumulator_if #(
   parameter int ACC_W = 72,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic [63:0]      p_in;
   logic             p_valid;
   logic             p_ready;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overflow;

   modport master (
      output start, len, p_in, p_valid, out_ready,
      input  p_ready, acc_out, out_valid, busy, overflow
   );

   modport slave (
      input  start, len, p_in, p_valid, out_ready,
      output p_ready, acc_out, out_valid, busy, overflow
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmable-length burst of 64-bit products into an ACC_W-bit accumulator.
// Optional saturating arithmetic is enabled by defining PRODUCT_ACC_SAT_EN.
module product_accumulator #(
   parameter int ACC_W = 72,
   parameter int LEN_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   product_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q;
   logic [ACC_W:0]   sum;
   logic             beat;

   // Extra top bit of sum is the carry out of the accumulator.
   assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - 64){1'b0}}, bus.p_in};
   assign beat = (state_q == ACCUM) && bus.p_valid;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               rem_d = bus.len;
               if (bus.len == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
`ifdef PRODUCT_ACC_SAT_EN
               acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
               acc_d = sum[ACC_W-1:0];
`endif
               ovf_d = ovf_q | sum[ACC_W];
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign bus.p_ready   = (state_q == ACCUM);
   assign bus.acc_out   = acc_q;
   assign bus.overflow  = ovf_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives identical bursts into a 72-bit and a 64-bit accumulator and compares both
// against an unbounded-integer reference sum.
module tb_product_accumulator;

   localparam int LEN_W = 8;
   localparam logic [63:0] MAX_P = 64'hFFFF_FFFE_0000_0001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [63:0]      p_in = '0;
   logic             p_valid = 1'b0;
   logic             out_ready = 1'b0;

   always #5 clk = ~clk;

   product_accumulator_if #(.ACC_W(72), .LEN_W(LEN_W)) bus_w ();
   product_accumulator_if #(.ACC_W(64), .LEN_W(LEN_W)) bus_n ();

   assign bus_w.start     = start;
   assign bus_w.len       = len;
   assign bus_w.p_in      = p_in;
   assign bus_w.p_valid   = p_valid;
   assign bus_w.out_ready = out_ready;
   assign bus_n.start     = start;
   assign bus_n.len       = len;
   assign bus_n.p_in      = p_in;
   assign bus_n.p_valid   = p_valid;
   assign bus_n.out_ready = out_ready;

   product_accumulator #(.ACC_W(72), .LEN_W(LEN_W)) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_w)
   );

   product_accumulator #(.ACC_W(64), .LEN_W(LEN_W)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_n)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] prods[$];
   bit          early_valid, ready_miss, unstable;

   // Reference: exact sum of the burst, then reduced to a w-bit register.
   function automatic logic [127:0] model_total();
      logic [127:0] t = '0;
      foreach (prods[i]) t += {64'd0, prods[i]};
      return t;
   endfunction

   function automatic bit model_ovf(input logic [127:0] tot, input int w);
      return tot >= (128'd1 << w);
   endfunction

   function automatic logic [71:0] model_acc(input logic [127:0] tot, input int w);
      logic [127:0] lim = 128'd1 << w;
`ifdef PRODUCT_ACC_SAT_EN
      if (tot >= lim) return 72'(lim - 128'd1);
`endif
      return 72'(tot & (lim - 128'd1));
   endfunction

   function automatic logic [63:0] rand_prod();
      case ($urandom_range(3))
         0:       return MAX_P;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Stimulus only: start a burst of prods, insert gap idle cycles before each beat.
   task automatic send_burst(input int gap, input bit poke_start);
      early_valid = 1'b0;
      ready_miss  = 1'b0;
      start = 1'b1;
      len   = LEN_W'(prods.size());
      @(negedge clk);
      start = 1'b0;
      len   = LEN_W'($urandom);
      foreach (prods[i]) begin
         for (int g = 0; g < gap; g++) begin
            if (bus_w.out_valid || bus_n.out_valid) early_valid = 1'b1;
            p_valid = 1'b0;
            p_in    = {$urandom, $urandom};
            if (poke_start) begin
               start = 1'b1;
               len   = '0;
            end
            @(negedge clk);
            start = 1'b0;
         end
         if (bus_w.out_valid || bus_n.out_valid) early_valid = 1'b1;
         if (!bus_w.p_ready || !bus_n.p_ready) ready_miss = 1'b1;
         p_valid = 1'b1;
         p_in    = prods[i];
         @(negedge clk);
      end
      p_valid = 1'b0;
      p_in    = {$urandom, $urandom};
   endtask

   // Stimulus only: hold out_ready low for hold cycles with junk on the inputs, then handshake.
   task automatic drain(input int hold);
      logic [71:0] aw0;
      logic [63:0] an0;
      aw0 = bus_w.acc_out;
      an0 = bus_n.acc_out;
      unstable = 1'b0;
      for (int h = 0; h < hold; h++) begin
         p_valid   = 1'($urandom);
         p_in      = {$urandom, $urandom};
         start     = 1'($urandom);
         len       = LEN_W'($urandom);
         out_ready = 1'b0;
         @(negedge clk);
         if (!bus_w.out_valid || !bus_n.out_valid || bus_w.p_ready || bus_n.p_ready ||
             !bus_w.busy || !bus_n.busy || bus_w.acc_out !== aw0 || bus_n.acc_out !== an0)
            unstable = 1'b1;
      end
      start     = 1'b0;
      p_valid   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({bus_w.acc_out, bus_w.out_valid, bus_w.p_ready, bus_w.busy, bus_w.overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset72: got acc=%h v=%b r=%b b=%b o=%b, want all 0", bus_w.acc_out,
                  bus_w.out_valid, bus_w.p_ready, bus_w.busy, bus_w.overflow);
      end
      n_checks++;
      if ({bus_n.acc_out, bus_n.out_valid, bus_n.p_ready, bus_n.busy, bus_n.overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset64: got acc=%h v=%b r=%b b=%b o=%b, want all 0", bus_n.acc_out,
                  bus_n.out_valid, bus_n.p_ready, bus_n.busy, bus_n.overflow);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Checks the result presented just after a burst, one cycle after its last beat.
   task automatic test_burst(input string name, input int gap, input bit poke, input int hold);
      logic [127:0] tot;
      tot = model_total();
      send_burst(gap, poke);
      n_checks++;
      if (early_valid || ready_miss || !bus_w.out_valid || !bus_n.out_valid) begin
         n_fail++;
         $display("FAIL %s timing: early=%b ready_miss=%b valid=%b/%b, want 0 0 1/1", name,
                  early_valid, ready_miss, bus_w.out_valid, bus_n.out_valid);
      end
      n_checks++;
      if (bus_w.acc_out !== model_acc(tot, 72) || bus_w.overflow !== model_ovf(tot, 72)) begin
         n_fail++;
         $display("FAIL %s acc72: got %h ovf=%b, want %h ovf=%b", name, bus_w.acc_out,
                  bus_w.overflow, model_acc(tot, 72), model_ovf(tot, 72));
      end
      n_checks++;
      if (72'(bus_n.acc_out) !== model_acc(tot, 64) || bus_n.overflow !== model_ovf(tot, 64)) begin
         n_fail++;
         $display("FAIL %s acc64: got %h ovf=%b, want %h ovf=%b", name, bus_n.acc_out,
                  bus_n.overflow, model_acc(tot, 64), model_ovf(tot, 64));
      end
      drain(hold);
      n_checks++;
      if (unstable || bus_w.out_valid || bus_n.out_valid || bus_w.busy || bus_n.busy ||
          bus_w.acc_out !== model_acc(tot, 72)) begin
         n_fail++;
         $display("FAIL %s release: unstable=%b valid=%b/%b busy=%b/%b acc=%h, want 0 0/0 0/0 %h",
                  name, unstable, bus_w.out_valid, bus_n.out_valid, bus_w.busy, bus_n.busy,
                  bus_w.acc_out, model_acc(tot, 72));
      end
   endtask

   task automatic test_basic();
      prods = '{64'h0C, 64'h0, 64'h0000_0000_FFFF_FFFF};
      test_burst("basic", 0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      prods = '{64'h0C, 64'h0, 64'h0000_0000_FFFF_FFFF};
      test_burst("backpressure", 2, 1'b1, 5);
   endtask

   task automatic test_overflow();
      prods = '{MAX_P, MAX_P};
      test_burst("overflow", 0, 1'b0, 1);
      prods.delete();
      repeat (255) prods.push_back(MAX_P);
      test_burst("full_burst", 0, 1'b0, 0);
   endtask

   task automatic test_zero_len();
      start = 1'b1;
      len   = '0;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (!bus_w.out_valid || !bus_n.out_valid || bus_w.acc_out !== '0 || bus_n.acc_out !== '0) begin
         n_fail++;
         $display("FAIL zero_len: valid=%b/%b acc=%h/%h, want 1/1 0/0", bus_w.out_valid,
                  bus_n.out_valid, bus_w.acc_out, bus_n.acc_out);
      end
      for (int k = 0; k < 3; k++) begin
         p_valid = 1'b1;
         p_in    = 64'h1234;
         @(negedge clk);
         n_checks++;
         if (bus_w.acc_out !== '0 || bus_n.acc_out !== '0 || bus_w.p_ready || !bus_w.out_valid) begin
            n_fail++;
            $display("FAIL zero_len_ignore: acc=%h/%h p_ready=%b valid=%b, want 0/0 0 1",
                     bus_w.acc_out, bus_n.acc_out, bus_w.p_ready, bus_w.out_valid);
         end
      end
      p_valid = 1'b0;
      drain(0);
   endtask

   task automatic test_random();
      for (int b = 0; b < 8; b++) begin
         prods.delete();
         repeat ($urandom_range(24, 1)) prods.push_back(rand_prod());
         test_burst($sformatf("random%0d", b), $urandom_range(2), 1'($urandom), $urandom_range(3));
      end
   endtask

   // A new burst is started on the very cycle after the result handshake.
   task automatic test_back_to_back();
      prods = '{64'd7, 64'd9};
      test_burst("b2b_first", 0, 1'b0, 0);
      prods = '{64'd100};
      test_burst("b2b_second", 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      logic [127:0] tot;
      prods = '{{$urandom, $urandom}, {$urandom, $urandom}};
      tot   = model_total();
      start = 1'b1;
      len   = LEN_W'(4);
      @(negedge clk);
      start = 1'b0;
      foreach (prods[i]) begin
         p_valid = 1'b1;
         p_in    = prods[i];
         @(negedge clk);
      end
      p_valid = 1'b0;
      n_checks++;
      if (bus_w.acc_out !== model_acc(tot, 72) || !bus_w.busy || bus_w.out_valid) begin
         n_fail++;
         $display("FAIL mid_partial: acc=%h busy=%b valid=%b, want %h 1 0", bus_w.acc_out,
                  bus_w.busy, bus_w.out_valid, model_acc(tot, 72));
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_w.acc_out, bus_w.out_valid, bus_w.p_ready, bus_w.busy, bus_w.overflow,
           bus_n.acc_out, bus_n.out_valid, bus_n.p_ready, bus_n.busy, bus_n.overflow} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: acc=%h/%h valid=%b ready=%b busy=%b, want all 0",
                  bus_w.acc_out, bus_n.acc_out, bus_w.out_valid, bus_w.p_ready, bus_w.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      prods = '{64'd5};
      test_burst("after_reset", 0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_overflow();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
